// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: command input, ALU issue/return and result output
// signals of the ALU command sequencer, bundled for port connection.
// Handshake semantics (both in_* and out_* ports): a transfer happens on a
// rising clk edge where valid && ready are both high; the sender holds its
// payload stable while valid && !ready, and ready never depends
// combinationally on valid.
// slave  = the sequencer itself; master = the environment around it
// (command producer, ALU and result consumer).
interface alu_op_sequencer_if #(
  parameter int FIFO_DEPTH = 4
) ();
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_a;
  logic [3:0]    in_b;
  logic [2:0]    in_sel;
  logic          in_use_acc;

  logic [3:0]    alu_a;
  logic [3:0]    alu_b;
  logic [2:0]    alu_sel;
  logic [3:0]    alu_result;
  logic          alu_carry;
  logic          alu_borrow;

  logic          out_valid;
  logic          out_ready;
  logic [3:0]    out_result;
  logic          out_flag;
  logic [2:0]    out_sel;

  logic [CW-1:0] count;
  logic          busy;
  logic [1:0]    dbg_state;

  modport slave (
    input  in_valid, in_a, in_b, in_sel, in_use_acc,
    input  alu_result, alu_carry, alu_borrow,
    input  out_ready,
    output in_ready, alu_a, alu_b, alu_sel,
    output out_valid, out_result, out_flag, out_sel,
    output count, busy, dbg_state
  );

  modport master (
    output in_valid, in_a, in_b, in_sel, in_use_acc,
    output alu_result, alu_carry, alu_borrow,
    output out_ready,
    input  in_ready, alu_a, alu_b, alu_sel,
    input  out_valid, out_result, out_flag, out_sel,
    input  count, busy, dbg_state
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: buffers ALU commands in a small FIFO, issues one at a
// time on registered alu_a/alu_b/alu_sel, captures the ALU result and the
// op-qualified carry/borrow flag one cycle later and holds it on a
// valid/ready output.
// Optional feature macro: ALU_SEQ_ACC_EN adds a 4-bit accumulator that can
// replace operand a on commands flagged with use_acc.
module alu_op_sequencer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_op_sequencer_if.slave   bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_RESULT = 2'd2
  } state_t;

  state_t        r_state;
  logic [3:0]    r_mem_a   [FIFO_DEPTH];
  logic [3:0]    r_mem_b   [FIFO_DEPTH];
  logic [2:0]    r_mem_sel [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [3:0]    r_alu_a;
  logic [3:0]    r_alu_b;
  logic [2:0]    r_alu_sel;
  logic          r_out_valid;
  logic [3:0]    r_out_result;
  logic          r_out_flag;
  logic [2:0]    r_out_sel;

  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_flag;
  logic [3:0]    w_head_a;

`ifdef ALU_SEQ_ACC_EN
  logic          r_mem_acc [FIFO_DEPTH];
  logic [3:0]    r_acc;

  // Operand a of the head entry, taken from the accumulator when flagged.
  assign w_head_a = r_mem_acc[r_rd_ptr] ? r_acc : r_mem_a[r_rd_ptr];
`else
  logic          w_unused_use_acc;

  // Without the accumulator the use_acc input has no effect.
  assign w_unused_use_acc = bus.in_use_acc;
  assign w_head_a         = r_mem_a[r_rd_ptr];
`endif

  // Full is derived from registered count only, so in_ready never sees out_ready.
  assign w_full = (r_count == FULL_COUNT);
  assign w_push = bus.in_valid && !w_full;
  // Pop from IDLE, or from RESULT in the cycle the held result is consumed.
  assign w_pop  = (r_count != '0) &&
                  ((r_state == S_IDLE) || ((r_state == S_RESULT) && bus.out_ready));

  // Flag qualification: the ALU flags are only meaningful for add and sub.
  always_comb begin
    w_flag = 1'b0;
    case (r_alu_sel)
      3'b000:  w_flag = bus.alu_carry;
      3'b001:  w_flag = bus.alu_borrow;
      default: w_flag = 1'b0;
    endcase
  end

  // FIFO storage write; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_a[r_wr_ptr]   <= bus.in_a;
      r_mem_b[r_wr_ptr]   <= bus.in_b;
      r_mem_sel[r_wr_ptr] <= bus.in_sel;
`ifdef ALU_SEQ_ACC_EN
      r_mem_acc[r_wr_ptr] <= bus.in_use_acc;
`endif
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at a power-of-2 depth.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Issue/capture FSM with all alu_* and out_* outputs registered here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_sel    <= '0;
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_flag   <= 1'b0;
      r_out_sel    <= '0;
`ifdef ALU_SEQ_ACC_EN
      r_acc        <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_alu_a   <= w_head_a;
            r_alu_b   <= r_mem_b[r_rd_ptr];
            r_alu_sel <= r_mem_sel[r_rd_ptr];
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_out_result <= bus.alu_result;
          r_out_flag   <= w_flag;
          r_out_sel    <= r_alu_sel;
          r_out_valid  <= 1'b1;
`ifdef ALU_SEQ_ACC_EN
          r_acc        <= bus.alu_result;
`endif
          r_state      <= S_RESULT;
        end
        S_RESULT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            if (w_pop) begin
              r_alu_a   <= w_head_a;
              r_alu_b   <= r_mem_b[r_rd_ptr];
              r_alu_sel <= r_mem_sel[r_rd_ptr];
              r_state   <= S_ISSUE;
            end else begin
              r_state   <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = !w_full;
  assign bus.alu_a      = r_alu_a;
  assign bus.alu_b      = r_alu_b;
  assign bus.alu_sel    = r_alu_sel;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_result = r_out_result;
  assign bus.out_flag   = r_out_flag;
  assign bus.out_sel    = r_out_sel;
  assign bus.count      = r_count;
  assign bus.busy       = (r_state != S_IDLE) || (r_count != '0);
  assign bus.dbg_state  = r_state;
endmodule
